// File: rtl/sme_driver.sv
// sme_driver: initiator-side front end for the string-matching engine (SME).
//
// The host fills a string buffer and up to PAT_NUM pattern buffers, then pulses
// start. The block streams the string once, then each pattern in turn, to the
// SME and waits for its valid. It returns one result record per pattern.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   clr               zero all buffer lengths (ignored while busy)
//   wr_en/wr_sel/     append wr_data to the string (wr_sel=0) or to pattern
//   wr_pid/wr_data    slot wr_pid (wr_sel=1); ignored while busy
//   start, pat_num    begin a run over patterns 0..pat_num-1
//   busy, done        run in progress / one-cycle end-of-run pulse
//   chardata,         character stream to the SME
//   isstring/ispattern
//   match,            SME response, sampled only while waiting for it
//   match_index/valid
//   res_valid, res_*  one-cycle result strobe and held result fields
//
// Optional feature: define SME_DRV_TIMEOUT_EN to bound the wait for valid to
// TIMEOUT cycles; otherwise res_timeout is tied to 0.
//
// Port widths are sized for the default parameter values.

module sme_driver #(
    parameter int unsigned STR_MAX = 32,
    parameter int unsigned PAT_LEN = 8,
    parameter int unsigned PAT_NUM = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [1:0] wr_pid,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic [2:0] pat_num,
    output logic       busy,
    output logic       done,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       match,
    input  logic [4:0] match_index,
    input  logic       valid,
    output logic       res_valid,
    output logic [1:0] res_pid,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_timeout
);

    typedef enum logic [2:0] {StIdle, StSendStr, StSendPat, StWait, StNext} state_e;

    // ------------------------------------------------------------------
    // Buffers
    // ------------------------------------------------------------------
    logic [7:0] str_mem [STR_MAX];
    logic [7:0] pat_mem [PAT_NUM][PAT_LEN];
    logic [5:0] str_len_q;
    logic [3:0] pat_len_q [PAT_NUM];

    logic str_room;
    logic pat_room;
    logic wr_ok;

    assign str_room = (str_len_q < 6'(STR_MAX));
    assign pat_room = (pat_len_q[wr_pid] < 4'(PAT_LEN));
    assign wr_ok    = wr_en && !clr && !busy;

    // Contents need no reset; only the lengths define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (!wr_sel) begin
                if (str_room) str_mem[str_len_q[4:0]] <= wr_data;
            end else if (pat_room) begin
                pat_mem[wr_pid][pat_len_q[wr_pid][2:0]] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            str_len_q <= '0;
            for (int i = 0; i < int'(PAT_NUM); i++) pat_len_q[i] <= '0;
        end else if (!busy) begin
            if (clr) begin
                str_len_q <= '0;
                for (int i = 0; i < int'(PAT_NUM); i++) pat_len_q[i] <= '0;
            end else if (wr_en) begin
                if (!wr_sel) begin
                    if (str_room) str_len_q <= str_len_q + 6'd1;
                end else if (pat_room) begin
                    pat_len_q[wr_pid] <= pat_len_q[wr_pid] + 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [4:0] idx_q, idx_d;       // character index within string or pattern
    logic [1:0] pid_q, pid_d;       // current pattern slot
    logic [2:0] npat_q, npat_d;     // pat_num latched at start

    logic       start_ok;
    logic [3:0] cur_len;
    logic       hit;                // SME answered while waiting
    logic       report;             // a result is produced this cycle
    logic       report_to;          // that result is a timeout

    logic       busy_d, done_d, isstring_d, ispattern_d, res_valid_d;
    logic [7:0] chardata_d;
    logic [1:0] res_pid_d;
    logic       res_match_d, res_timeout_d;
    logic [4:0] res_index_d;

`ifdef SME_DRV_TIMEOUT_EN
    logic [7:0] tcnt_q, tcnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    assign start_ok = start && (str_len_q != '0) && (pat_num != '0) &&
                      (pat_num <= 3'(PAT_NUM));
    assign cur_len  = pat_len_q[pid_q];
    assign hit      = (state_q == StWait) && valid;

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            pid_q       <= '0;
            npat_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            chardata    <= '0;
            isstring    <= 1'b0;
            ispattern   <= 1'b0;
            res_valid   <= 1'b0;
            res_pid     <= '0;
            res_match   <= 1'b0;
            res_index   <= '0;
            res_timeout <= 1'b0;
`ifdef SME_DRV_TIMEOUT_EN
            tcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pid_q       <= pid_d;
            npat_q      <= npat_d;
            busy        <= busy_d;
            done        <= done_d;
            chardata    <= chardata_d;
            isstring    <= isstring_d;
            ispattern   <= ispattern_d;
            res_valid   <= res_valid_d;
            res_pid     <= res_pid_d;
            res_match   <= res_match_d;
            res_index   <= res_index_d;
            res_timeout <= res_timeout_d;
`ifdef SME_DRV_TIMEOUT_EN
            tcnt_q      <= tcnt_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pid_d     = pid_q;
        npat_d    = npat_q;
        report    = 1'b0;
        report_to = 1'b0;
`ifdef SME_DRV_TIMEOUT_EN
        tcnt_d    = tcnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = StSendStr;
                    idx_d   = '0;
                    pid_d   = '0;
                    npat_d  = pat_num;
                end
            end
            StSendStr: begin
                if ({1'b0, idx_q} == str_len_q - 6'd1) begin
                    state_d = StSendPat;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            StSendPat: begin
                if (cur_len == '0) begin
                    // Empty slot: nothing goes to the SME, report a miss.
                    state_d = StNext;
                    report  = 1'b1;
                end else if (idx_q == {1'b0, cur_len - 4'd1}) begin
                    state_d = StWait;
`ifdef SME_DRV_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            StWait: begin
                if (valid) begin
                    state_d = StNext;
                    report  = 1'b1;
                end
`ifdef SME_DRV_TIMEOUT_EN
                else if (tcnt_q == 8'(TIMEOUT - 1)) begin
                    state_d   = StNext;
                    report    = 1'b1;
                    report_to = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
`endif
            end
            StNext: begin
                if ({1'b0, pid_q} + 3'd1 == npat_q) begin
                    state_d = StIdle;
                end else begin
                    state_d = StSendPat;
                    pid_d   = pid_q + 2'd1;
                    idx_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: computed from the upcoming state so every output is a flop.
    always_comb begin
        busy_d        = (state_d != StIdle);
        done_d        = (state_q == StNext) && (state_d == StIdle);
        isstring_d    = 1'b0;
        ispattern_d   = 1'b0;
        chardata_d    = '0;
        res_valid_d   = report;
        res_pid_d     = res_pid;
        res_match_d   = res_match;
        res_index_d   = res_index;
        res_timeout_d = res_timeout;

        if (state_d == StSendStr) begin
            isstring_d = 1'b1;
            chardata_d = str_mem[idx_d];
        end else if (state_d == StSendPat && pat_len_q[pid_d] != '0) begin
            ispattern_d = 1'b1;
            chardata_d  = pat_mem[pid_d][idx_d[2:0]];
        end

        if (report) begin
            res_pid_d     = pid_q;
            res_match_d   = hit && match;
            res_index_d   = hit ? match_index : '0;
            res_timeout_d = report_to;
        end
    end

endmodule

// File: tb/tb_sme_driver.sv
// Randomised bench for sme_driver. Expected SME traffic and result records are
// derived from a queue model of the buffers and pushed before each start; a
// monitor compares every driven character, result and done pulse against them.
module tb_sme_driver;

    localparam int TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr = 1'b0;
    logic       wr_en = 1'b0;
    logic       wr_sel = 1'b0;
    logic [1:0] wr_pid = '0;
    logic [7:0] wr_data = '0;
    logic       start = 1'b0;
    logic [2:0] pat_num = '0;
    logic       busy, done, isstring, ispattern;
    logic [7:0] chardata;
    logic       match = 1'b0;
    logic [4:0] match_index = '0;
    logic       valid = 1'b0;
    logic       res_valid, res_match, res_timeout;
    logic [1:0] res_pid;
    logic [4:0] res_index;

    always #5 clk = ~clk;

    sme_driver dut (
        .clk         (clk),
        .reset       (reset),
        .clr         (clr),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_pid      (wr_pid),
        .wr_data     (wr_data),
        .start       (start),
        .pat_num     (pat_num),
        .busy        (busy),
        .done        (done),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .match       (match),
        .match_index (match_index),
        .valid       (valid),
        .res_valid   (res_valid),
        .res_pid     (res_pid),
        .res_match   (res_match),
        .res_index   (res_index),
        .res_timeout (res_timeout)
    );

    typedef struct packed {logic s; logic [7:0] c;} chr_t;
    typedef struct {logic [1:0] pid; logic m; logic [4:0] idx; logic to; int gap;} res_t;
    typedef struct {logic m; logic [4:0] idx; int lat;} rsp_t;

    chr_t chr_q[$];
    res_t res_q[$];
    rsp_t rsp_q[$];
    logic [7:0] m_str[$];
    logic [7:0] m_pat[4][$];

    int n_cmp = 0, n_err = 0;
    int done_cnt = 0, done_exp = 0;
    int cyc = 0, last_pat_cyc = 0;
    bit mon_on = 1'b1;
    bit prev_rv = 1'b0;
    bit prev_ip = 1'b0;
    chr_t e;
    res_t r;
    rsp_t rs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {10'd0, busy, done, chardata, isstring, ispattern, res_valid, res_pid,
                res_match, res_index, res_timeout};
    endfunction

    // Monitor / scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (mon_on && reset) begin
            if (isstring || ispattern) begin
                if (chr_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_char: got s=%0b p=%0b c=0x%0h, want no traffic",
                             isstring, ispattern, chardata);
                end else begin
                    e = chr_q.pop_front();
                    chk("char", {23'd0, isstring, ispattern, chardata}, {23'd0, e.s, !e.s, e.c});
                end
                if (ispattern) last_pat_cyc = cyc;
            end else begin
                chk("idle_chardata", {24'd0, chardata}, 32'd0);
            end
            if (res_valid) begin
                if (res_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got pid=%0d, want no result", res_pid);
                end else begin
                    r = res_q.pop_front();
                    chk("res_pid", {30'd0, res_pid}, {30'd0, r.pid});
                    chk("res_match", {31'd0, res_match}, {31'd0, r.m});
                    chk("res_timeout", {31'd0, res_timeout}, {31'd0, r.to});
                    if (!r.to) chk("res_index", {27'd0, res_index}, {27'd0, r.idx});
                    if (r.gap != 0) chk("res_latency", cyc - last_pat_cyc, r.gap);
                end
            end
            if (done) begin
                chk("done_after_res", {31'd0, prev_rv}, 32'd1);
                chk("busy_low_at_done", {31'd0, busy}, 32'd0);
                done_cnt++;
            end
        end
        prev_rv = res_valid;
    end

    // SME model: answers after rsp.lat WAIT cycles once a pattern has been sent.
    initial begin
        forever begin
            @(negedge clk);
            if (prev_ip && !ispattern && reset && rsp_q.size() > 0) begin
                rs = rsp_q.pop_front();
                repeat (rs.lat - 1) @(negedge clk);
                valid = 1'b1;
                match = rs.m;
                match_index = rs.idx;
                @(negedge clk);
                valid = 1'b0;
                match = 1'($urandom);
                match_index = 5'($urandom);
            end
            prev_ip = ispattern;
        end
    end

    task automatic model_clear();
        m_str.delete();
        for (int k = 0; k < 4; k++) m_pat[k].delete();
    endtask

    task automatic flush();
        chr_q.delete();
        res_q.delete();
        rsp_q.delete();
    endtask

    task automatic wr(input logic sel, input logic [1:0] pid, input logic [7:0] d);
        wr_en = 1'b1;
        wr_sel = sel;
        wr_pid = pid;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (!sel) begin
            if (m_str.size() < 32) m_str.push_back(d);
        end else if (m_pat[pid].size() < 8) begin
            m_pat[pid].push_back(d);
        end
    endtask

    task automatic wr_str(input string s);
        for (int i = 0; i < s.len(); i++) wr(1'b0, 2'd0, s[i]);
    endtask

    task automatic wr_pat(input int pid, input string s);
        for (int i = 0; i < s.len(); i++) wr(1'b1, 2'(pid), s[i]);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        flush();
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // mode: 0 random SME response, 1 fixed response, 2 SME never answers.
    task automatic run(input int n, input int mode, input logic fm, input logic [4:0] fidx,
                       input int flat, input bit junk);
        res_t x;
        rsp_t y;
        int i;
        for (int j = 0; j < m_str.size(); j++) chr_q.push_back({1'b1, m_str[j]});
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < m_pat[k].size(); j++) chr_q.push_back({1'b0, m_pat[k][j]});
            x.pid = 2'(k);
            if (m_pat[k].size() == 0) begin
                x.m = 1'b0; x.idx = '0; x.to = 1'b0; x.gap = 0;
            end else if (mode == 2) begin
                x.m = 1'b0; x.idx = '0; x.to = 1'b1; x.gap = TIMEOUT + 1;
            end else begin
                y.m   = (mode == 1) ? fm : 1'($urandom);
                y.idx = (mode == 1) ? fidx : 5'($urandom);
                y.lat = (mode == 1) ? flat : int'($urandom_range(1, 5));
                rsp_q.push_back(y);
                x.m = y.m; x.idx = y.idx; x.to = 1'b0; x.gap = y.lat + 1;
            end
            res_q.push_back(x);
        end
        done_exp++;
        pat_num = 3'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pat_num = 3'($urandom);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("isstring_after_start", {31'd0, isstring}, 32'd1);
        for (i = 0; i < 3000 && done_cnt < done_exp; i++) begin
            if (junk) begin
                wr_en = busy;
                clr = busy & 1'($urandom);
                wr_sel = 1'($urandom);
                wr_pid = 2'($urandom);
                wr_data = 8'($urandom);
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        clr = 1'b0;
        if (done_cnt < done_exp) begin
            n_cmp++;
            n_err++;
            $display("FAIL run_no_done: got no done within 3000 cycles, want done");
            do_reset();
            done_cnt = done_exp;
        end
        chk("leftover_chars", chr_q.size(), 32'd0);
        chk("leftover_results", res_q.size(), 32'd0);
        flush();
    endtask

    task automatic try_bad_start(input logic [2:0] n);
        pat_num = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            chk("busy_ignored_start", {31'd0, busy}, 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        int ns, lp;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Basic single-pattern run with a known SME answer.
        wr_str("ab cd");
        wr_pat(0, "cd");
        run(1, 1, 1'b1, 5'd3, 4, 1'b0);

        // Three patterns, string sent once; rerun to confirm busy-time writes were dropped.
        do_clr();
        wr_str("ab cd");
        wr_pat(0, "^a");
        wr_pat(1, "x");
        wr_pat(2, "d$");
        run(3, 0, 1'b0, 5'd0, 0, 1'b1);
        run(3, 0, 1'b0, 5'd0, 0, 1'b0);

        // String overflow: only the first 32 of 40 characters are kept.
        do_clr();
        for (int i = 0; i < 40; i++) wr(1'b0, 2'd0, 8'($urandom_range(33, 126)));
        wr_pat(0, "zq!");
        run(1, 0, 1'b0, 5'd0, 0, 1'b0);

        // Empty slot 1.
        do_clr();
        wr_str("hello");
        wr_pat(0, "lo");
        run(2, 0, 1'b0, 5'd0, 0, 1'b0);

        // Starts that must be ignored.
        do_clr();
        wr_pat(0, "a");
        try_bad_start(3'd1);
        wr_str("xy");
        try_bad_start(3'd0);
        try_bad_start(3'd5);
        try_bad_start(3'd7);
        run(1, 0, 1'b0, 5'd0, 0, 1'b0);

        // clr wins over a simultaneous write: string stays empty.
        clr = 1'b1;
        wr_en = 1'b1;
        wr_sel = 1'b0;
        wr_data = "z";
        @(negedge clk);
        clr = 1'b0;
        wr_en = 1'b0;
        model_clear();
        wr_pat(0, "k");
        try_bad_start(3'd1);

        // Randomised loads and runs, including overfull and empty patterns.
        for (int it = 0; it < 25; it++) begin
            do_clr();
            ns = $urandom_range(1, 36);
            for (int i = 0; i < ns; i++) wr(1'b0, 2'd0, 8'($urandom_range(32, 126)));
            for (int k = 0; k < 4; k++) begin
                lp = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 10));
                for (int i = 0; i < lp; i++) wr(1'b1, 2'(k), 8'($urandom_range(32, 126)));
            end
            run($urandom_range(1, 4), 0, 1'b0, 5'd0, 0, bit'(it % 2));
        end

        // Asynchronous reset in the middle of a pattern.
        do_clr();
        wr_str("abc");
        wr_pat(0, "12345678");
        mon_on = 1'b0;
        pat_num = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !ispattern; i++) @(negedge clk);
        chk("reached_send_pat", {31'd0, ispattern}, 32'd1);
        #2 reset = 1'b0;
        #1 chk("async_reset_outputs", all_outs(), 32'd0);
        flush();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mon_on = 1'b1;
        wr_pat(0, "q");
        try_bad_start(3'd1);

`ifdef SME_DRV_TIMEOUT_EN
        // SME never answers: each pattern times out.
        do_clr();
        wr_str("abc");
        wr_pat(0, "b");
        wr_pat(1, "c");
        run(2, 2, 1'b0, 5'd0, 0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
